// File: rtl/multicycle_controller.sv
// Multicycle MIPS-style control FSM: registered per-state controls, shared memory handshake.
// Define ILLEGAL_OP_TRAP_EN to trap on illegal opcodes; otherwise they retire as NOPs.
module multicycle_controller #(
   parameter int unsigned n       = 16,
   parameter int unsigned STATE_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [4:0]         op,
   input  logic [3:0]         funct,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               memwrite,
   output logic               iord,
   output logic               irwrite,
   output logic               pcwrite,
   output logic [1:0]         pcsrc,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [3:0]         alucontrol,
   output logic               regdst,
   output logic               memtoreg,
   output logic               regwrite,
   output logic               halted,
   output logic [STATE_W-1:0] dbg_state
);
   typedef enum logic [3:0] {
      StFetch  = 4'd0,  StDecode = 4'd1,  StMemAdr = 4'd2,  StMemRd  = 4'd3,
      StMemWb  = 4'd4,  StMemWr  = 4'd5,  StExec   = 4'd6,  StAluWb  = 4'd7,
      StBranch = 4'd8,  StAddiEx = 4'd9,  StAddiWb = 4'd10, StJump   = 4'd11,
      StHalt   = 4'd12, StTrap   = 4'd13
   } state_e;

   localparam logic [4:0] OpRtype = 5'b00000;
   localparam logic [4:0] OpAddi  = 5'b00001;
   localparam logic [4:0] OpLw    = 5'b00010;
   localparam logic [4:0] OpSw    = 5'b00011;
   localparam logic [4:0] OpBeq   = 5'b00100;
   localparam logic [4:0] OpJ     = 5'b00101;
   localparam logic [4:0] OpHalt  = 5'b11111;
   localparam logic [3:0] AluAdd  = 4'b0010;
   localparam logic [3:0] AluSub  = 4'b0110;

   if (n == 0 || STATE_W < 4) begin : g_param_check
      $error("multicycle_controller: n must be nonzero and STATE_W at least 4");
   end

   state_e state_q, state_d;
   logic   jump_q;

   always_comb begin
      state_d = StFetch;
      case (state_q)
         // A fetch only completes once the request is actually on the bus.
         StFetch:  state_d = (mem_req && mem_ready) ? StDecode : StFetch;
         StDecode: begin
            case (op)
               OpRtype:     state_d = StExec;
               OpAddi:      state_d = StAddiEx;
               OpLw, OpSw:  state_d = StMemAdr;
               OpBeq:       state_d = StBranch;
               OpJ:         state_d = StJump;
               OpHalt:      state_d = StHalt;
`ifdef ILLEGAL_OP_TRAP_EN
               default:     state_d = StTrap;
`else
               default:     state_d = StFetch;
`endif
            endcase
         end
         StMemAdr: state_d = (op == OpLw) ? StMemRd : StMemWr;
         StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
         StMemWb:  state_d = StFetch;
         StMemWr:  state_d = mem_ready ? StFetch : StMemWr;
         StExec:   state_d = StAluWb;
         StAluWb:  state_d = StFetch;
         StBranch: state_d = StFetch;
         StAddiEx: state_d = StAddiWb;
         StAddiWb: state_d = StFetch;
         StJump:   state_d = StFetch;
         StHalt:   state_d = StHalt;
         StTrap:   state_d = StTrap;
         default:  state_d = StFetch;
      endcase
   end

   // Controls are registered from the next state so they line up with state_q.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StFetch;
         mem_req    <= 1'b0;
         memwrite   <= 1'b0;
         iord       <= 1'b0;
         alusrca    <= 1'b0;
         alusrcb    <= 2'b00;
         alucontrol <= 4'b0000;
         pcsrc      <= 2'b00;
         regdst     <= 1'b0;
         memtoreg   <= 1'b0;
         regwrite   <= 1'b0;
         halted     <= 1'b0;
         jump_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mem_req    <= 1'b0;
         memwrite   <= 1'b0;
         iord       <= 1'b0;
         alusrca    <= 1'b0;
         alusrcb    <= 2'b00;
         alucontrol <= 4'b0000;
         pcsrc      <= 2'b00;
         regdst     <= 1'b0;
         memtoreg   <= 1'b0;
         regwrite   <= 1'b0;
         halted     <= 1'b0;
         jump_q     <= 1'b0;
         case (state_d)
            StFetch:  begin mem_req <= 1'b1; alusrcb <= 2'b01; alucontrol <= AluAdd; end
            StDecode: begin alusrcb <= 2'b11; alucontrol <= AluAdd; end
            StMemAdr: begin alusrca <= 1'b1; alusrcb <= 2'b10; alucontrol <= AluAdd; end
            StMemRd:  begin mem_req <= 1'b1; iord <= 1'b1; end
            StMemWb:  begin regwrite <= 1'b1; memtoreg <= 1'b1; end
            StMemWr:  begin mem_req <= 1'b1; memwrite <= 1'b1; iord <= 1'b1; end
            StExec:   begin alusrca <= 1'b1; alucontrol <= funct; end
            StAluWb:  begin regwrite <= 1'b1; regdst <= 1'b1; end
            StBranch: begin alusrca <= 1'b1; alucontrol <= AluSub; pcsrc <= 2'b01; end
            StAddiEx: begin alusrca <= 1'b1; alusrcb <= 2'b10; alucontrol <= AluAdd; end
            StAddiWb: regwrite <= 1'b1;
            StJump:   begin jump_q <= 1'b1; pcsrc <= 2'b10; end
            StHalt, StTrap: halted <= 1'b1;
            default: ;
         endcase
      end
   end

   assign irwrite   = (state_q == StFetch) && mem_req && mem_ready;
   assign pcwrite   = jump_q || irwrite || ((state_q == StBranch) && zero);
   assign dbg_state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle check against a spec-level control model.
`timescale 1ns/1ps
module tb_multicycle_controller;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [4:0] op = 5'd0;
   logic [3:0] funct = 4'd0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, memwrite, iord, irwrite, pcwrite, alusrca, regdst, memtoreg;
   logic       regwrite, halted;
   logic [1:0] pcsrc, alusrcb;
   logic [3:0] alucontrol, dbg_state;
   logic [21:0] act;

   always #5 clk = ~clk;

   multicycle_controller #(.n(16), .STATE_W(4)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
      .pcwrite(pcwrite), .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
      .alucontrol(alucontrol), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
      .halted(halted), .dbg_state(dbg_state)
   );

   assign act = {mem_req, memwrite, iord, irwrite, pcwrite, pcsrc, alusrca, alusrcb,
                 alucontrol, regdst, memtoreg, regwrite, halted, dbg_state};

   // One expected cycle: spec state number, inputs applied, and whether it is the idle
   // cycle right after reset release (no request issued yet).
   typedef struct {
      int         st;
      bit         rdy;
      bit         z;
      bit         cold;
      logic [3:0] fn;
   } cyc_t;

   cyc_t q[$];
   cyc_t cur;
   int   checks = 0;
   int   errors = 0;
   int   n_memreq, n_iord, n_regwrite, n_memwrite, n_pcwrite, n_halted, n_ldwb;
   int   trace[$];

   function automatic logic [21:0] expect_ctrl(cyc_t c);
      logic mreq, mw, io, irw, pcw, asa, rd, mtr, rw, hl;
      logic [1:0] ps, asb;
      logic [3:0] ac;
      int s;
      s = c.st;
      if (c.cold) return '0;
      mreq = (s == 0 || s == 3 || s == 5);
      mw   = (s == 5);
      io   = (s == 3 || s == 5);
      irw  = (s == 0) && c.rdy;
      pcw  = irw || (s == 8 && c.z) || (s == 11);
      ps   = (s == 8) ? 2'b01 : (s == 11) ? 2'b10 : 2'b00;
      asa  = (s == 2 || s == 6 || s == 8 || s == 9);
      asb  = (s == 0) ? 2'b01 : (s == 1) ? 2'b11 : (s == 2 || s == 9) ? 2'b10 : 2'b00;
      ac   = (s == 6) ? c.fn : (s == 8) ? 4'b0110 :
             (s == 0 || s == 1 || s == 2 || s == 9) ? 4'b0010 : 4'b0000;
      rd   = (s == 7);
      mtr  = (s == 4);
      rw   = (s == 4 || s == 7 || s == 10);
      hl   = (s == 12 || s == 13);
      return {mreq, mw, io, irw, pcw, ps, asa, asb, ac, rd, mtr, rw, hl, 4'(s)};
   endfunction

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic compare_cycle();
      logic [21:0] want;
      want = expect_ctrl(cur);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL ctrl state %0d at %0t: got %h, expected %h", cur.st, $time, act, want);
      end
      n_memreq   += int'(mem_req);
      n_iord     += int'(iord);
      n_regwrite += int'(regwrite);
      n_memwrite += int'(memwrite);
      n_pcwrite  += int'(pcwrite);
      n_halted   += int'(halted);
      n_ldwb     += int'(regwrite && memtoreg);
      trace.push_back(int'(dbg_state));
   endtask

   task automatic step();
      @(posedge clk);
      #2;
      cur       = q.pop_front();
      mem_ready = cur.rdy;
      zero      = cur.z;
      @(negedge clk);
      compare_cycle();
   endtask

   task automatic push(input int st, input bit rdy, input bit z, input logic [3:0] fn);
      cyc_t c;
      c.st = st; c.rdy = rdy; c.z = z; c.cold = 1'b0; c.fn = fn;
      q.push_back(c);
   endtask

   // Builds the expected cycle list for one instruction, then drives it.
   task automatic do_instr(input logic [4:0] o, input logic [3:0] fn, input bit z,
                           input int fw, input int w, input int limit, output int ncyc);
      int steps;
      q.delete();
      trace.delete();
      n_memreq = 0; n_iord = 0; n_regwrite = 0; n_memwrite = 0;
      n_pcwrite = 0; n_halted = 0; n_ldwb = 0;
      for (int i = 0; i < fw; i++) push(0, 1'b0, z, fn);
      push(0, 1'b1, z, fn);
      push(1, 1'b1, z, fn);
      case (o)
         5'b00000: begin push(6, 1'b1, z, fn); push(7, 1'b1, z, fn); end
         5'b00001: begin push(9, 1'b1, z, fn); push(10, 1'b1, z, fn); end
         5'b00010: begin
            push(2, 1'b1, z, fn);
            for (int i = 0; i < w; i++) push(3, 1'b0, z, fn);
            push(3, 1'b1, z, fn);
            push(4, 1'b1, z, fn);
         end
         5'b00011: begin
            push(2, 1'b1, z, fn);
            for (int i = 0; i < w; i++) push(5, 1'b0, z, fn);
            push(5, 1'b1, z, fn);
         end
         5'b00100: push(8, 1'b1, z, fn);
         5'b00101: push(11, 1'b1, z, fn);
         5'b11111: for (int i = 0; i < 20; i++) push(12, 1'b1, z, fn);
         default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            for (int i = 0; i < 20; i++) push(13, 1'b1, z, fn);
`endif
         end
      endcase
      ncyc = q.size();
      step();
      op    = o;
      funct = fn;
      steps = 1;
      while (q.size() > 0 && steps < limit) begin
         step();
         steps++;
      end
   endtask

   task automatic apply_reset(input string name);
      @(posedge clk);
      #2;
      reset = 1'b0;
      q.delete();
      #1;
      chk({name, "_async_ctrl"}, int'(act), 0);
      @(posedge clk);
      #2;
      chk({name, "_hold_ctrl"}, int'(act), 0);
      mem_ready = 1'b1;
      reset     = 1'b1;
      cur.st = 0; cur.rdy = 1'b1; cur.z = 1'b0; cur.cold = 1'b1; cur.fn = 4'd0;
      @(negedge clk);
      compare_cycle();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: bench did not finish within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      int nc;
      int add_tr[4];
      add_tr = '{0, 1, 6, 7};
      #1 reset = 1'b0;
      @(posedge clk);
      #2;
      chk("reset_initial_ctrl", int'(act), 0);
      mem_ready = 1'b1;
      reset     = 1'b1;
      cur.st = 0; cur.rdy = 1'b1; cur.z = 1'b0; cur.cold = 1'b1; cur.fn = 4'd0;
      @(negedge clk);
      compare_cycle();

      // ADD with zero-wait memory
      do_instr(5'b00000, 4'b0010, 1'b1, 0, 0, 1000, nc);
      chk("add_latency", nc, 4);
      chk("add_trace_len", trace.size(), 4);
      for (int i = 0; i < 4; i++) chk($sformatf("add_trace_%0d", i), trace[i], add_tr[i]);
      chk("add_regwrite_count", n_regwrite, 1);

      // SUB via funct, then ADDI with one fetch wait
      do_instr(5'b00000, 4'b0110, 1'b0, 0, 0, 1000, nc);
      do_instr(5'b00001, 4'b1111, 1'b0, 1, 0, 1000, nc);
      chk("addi_latency_fetch_wait", nc, 5);
      chk("addi_regwrite_count", n_regwrite, 1);

      // LW zero-wait, then LW with three wait cycles in MEMRD
      do_instr(5'b00010, 4'd0, 1'b0, 0, 0, 1000, nc);
      chk("lw_latency", nc, 5);
      do_instr(5'b00010, 4'd0, 1'b0, 0, 3, 1000, nc);
      chk("lw_wait_latency", nc, 8);
      chk("lw_wait_memreq_cycles", n_memreq, 5);
      chk("lw_wait_iord_cycles", n_iord, 4);
      chk("lw_wait_load_wb", n_ldwb, 1);

      // SW zero-wait and with two waits
      do_instr(5'b00011, 4'd0, 1'b0, 0, 0, 1000, nc);
      chk("sw_latency", nc, 4);
      chk("sw_memwrite_cycles", n_memwrite, 1);
      do_instr(5'b00011, 4'd0, 1'b1, 0, 2, 1000, nc);
      chk("sw_wait_memwrite_cycles", n_memwrite, 3);
      chk("sw_wait_regwrite", n_regwrite, 0);

      // BEQ taken / not taken, then J
      do_instr(5'b00100, 4'd0, 1'b1, 0, 0, 1000, nc);
      chk("beq_latency", nc, 3);
      chk("beq_taken_pcwrites", n_pcwrite, 2);
      do_instr(5'b00100, 4'd0, 1'b0, 0, 0, 1000, nc);
      chk("beq_not_taken_pcwrites", n_pcwrite, 1);
      do_instr(5'b00101, 4'd0, 1'b0, 0, 0, 1000, nc);
      chk("j_latency", nc, 3);
      chk("j_pcwrites", n_pcwrite, 2);

      // Illegal opcode
      do_instr(5'b01010, 4'd0, 1'b0, 0, 0, 1000, nc);
      chk("illegal_regwrite", n_regwrite, 0);
      chk("illegal_memwrite", n_memwrite, 0);
`ifdef ILLEGAL_OP_TRAP_EN
      chk("illegal_trap_halted_cycles", n_halted, 20);
      apply_reset("trap_reset");
`else
      chk("illegal_nop_latency", nc, 2);
      chk("illegal_nop_halted", n_halted, 0);
`endif
      do_instr(5'b00000, 4'b0000, 1'b0, 0, 0, 1000, nc);

      // Reset asserted while a store waits on memory
      do_instr(5'b00011, 4'd0, 1'b0, 0, 6, 5, nc);
      chk("sw_abort_memwrite_before_reset", n_memwrite, 2);
      apply_reset("sw_abort_reset");
      do_instr(5'b00000, 4'b0111, 1'b0, 0, 0, 1000, nc);

      // HALT is absorbing
      do_instr(5'b11111, 4'd0, 1'b0, 0, 0, 1000, nc);
      chk("halt_halted_cycles", n_halted, 20);
      chk("halt_memreq_cycles", n_memreq, 1);
      apply_reset("halt_reset");
      do_instr(5'b00010, 4'd0, 1'b0, 1, 1, 1000, nc);
      chk("post_halt_lw_latency", nc, 7);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
